booth_mul4: RTL

Sequential signed multiplier for two's-complement operands, using radix-2 Booth recoding. It sits directly downstream of the 4-bit two's-complement negation stage. Its subtract step adds the negated multiplicand (~M + 1). It returns the product as a raw two's-complement value and as sign + magnitude for the display path. A start/busy/done handshake runs one multiplication at a time.

---
 rtl/booth_mul4.sv | 122 ++++++++++++
 1 files changed

// File: rtl/booth_mul4.sv
// Sequential radix-2 Booth multiplier for signed operands.
// One step per cycle; the result is given as a two's-complement value and as sign plus magnitude.
module booth_mul4 #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product,
    output logic [2*N-1:0] mag,
    output logic           neg
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [N:0]     acc;
    logic [N:0]     m_reg;
    logic [N-1:0]   q_reg;
    logic           q_1;
    logic [CW-1:0]  cnt;

    logic [N:0]     acc_sum;
    logic [N:0]     acc_next;
    logic [N-1:0]   q_next;
    logic           q1_next;
    logic [2*N-1:0] prod_next;
    logic [2*N-1:0] mag_next;
    logic           last_step;

    assign last_step = (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // One Booth step: the add/subtract is followed by an arithmetic shift of {A,Q,q_1}.
    always_comb begin
        acc_sum = acc;
        unique case ({q_reg[0], q_1})
            2'b01:   acc_sum = acc + m_reg;
            2'b10:   acc_sum = acc + ~m_reg + {{N{1'b0}}, 1'b1};
            default: acc_sum = acc;
        endcase
        acc_next  = {acc_sum[N], acc_sum[N:1]};
        q_next    = {acc_sum[0], q_reg[N-1:1]};
        q1_next   = q_reg[0];
        prod_next = {acc_next[N-1:0], q_next};
        mag_next  = prod_next[2*N-1] ? (~prod_next + {{(2*N-1){1'b0}}, 1'b1}) : prod_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc     <= '0;
            m_reg   <= '0;
            q_reg   <= '0;
            q_1     <= 1'b0;
            cnt     <= '0;
            product <= '0;
            mag     <= '0;
            neg     <= 1'b0;
        end else if (state == IDLE && start) begin
            acc   <= '0;
            m_reg <= {a[N-1], a};
            q_reg <= b;
            q_1   <= 1'b0;
            cnt   <= CW'(N);
        end else if (state == CALC) begin
            acc   <= acc_next;
            q_reg <= q_next;
            q_1   <= q1_next;
            cnt   <= cnt - 1'b1;
            // Outputs only move on the final step so they hold through later operations.
            if (last_step) begin
                product <= prod_next;
                mag     <= mag_next;
                neg     <= prod_next[2*N-1];
            end
        end
    end

endmodule
